// File: rtl/aes_cmd_initiator.sv
// AES config-port command master: writes key and plaintext halves, waits out the
// cipher pipeline, reads back both ciphertext halves, returns them on a
// valid/ready response channel. Optionally skips the key writes on a key repeat.
module aes_cmd_initiator #(
    parameter int unsigned WAIT_CYCLES = 14,
    parameter bit          KEY_CACHE   = 1'b1,
    parameter logic [15:0] ADDR_KEY_HI = 16'h0010,
    parameter logic [15:0] ADDR_KEY_LO = 16'h0020,
    parameter logic [15:0] ADDR_PT_HI  = 16'h0030,
    parameter logic [15:0] ADDR_PT_LO  = 16'h0040,
    parameter logic [15:0] ADDR_CT_HI  = 16'h0050,
    parameter logic [15:0] ADDR_CT_LO  = 16'h0060
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_plain,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [127:0] resp_cipher,
    output logic         resp_err,
    output logic         config_hsk,
    output logic [15:0]  config_addr,
    output logic [31:0]  config_data_hi,
    output logic [31:0]  config_data_lo,
    output logic         config_load,
    input  logic         aes_out_valid,
    input  logic [63:0]  aes_out_data
);

    typedef enum logic [3:0] {
        IDLE, WR_KH, WR_KL, WR_PH, WR_PL, WAIT, RD_H, RD_L, RESP
    } state_t;

    // Counter starts at WAIT_CYCLES-1 so WAIT lasts exactly WAIT_CYCLES cycles.
    localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [127:0]   key_q, key_d, plain_q, plain_d;
    logic [7:0]     cnt_q, cnt_d;
    logic           cache_vld_q, cache_vld_d;
    logic [127:0]   cache_key_q, cache_key_d;
    logic [127:0]   resp_cipher_q, resp_cipher_d;
    logic           resp_err_q, resp_err_d;
    logic           resp_valid_q, resp_valid_d;
    logic           req_ready_q, req_ready_d;
    logic           config_hsk_q, config_hsk_d;
    logic           config_load_q, config_load_d;
    logic [15:0]    config_addr_q, config_addr_d;
    logic [63:0]    config_data_q, config_data_d;

    // State and all registered outputs; reset also drops the key cache since the
    // target's key register contents are unknown after an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            key_q         <= '0;
            plain_q       <= '0;
            cnt_q         <= '0;
            cache_vld_q   <= 1'b0;
            cache_key_q   <= '0;
            resp_cipher_q <= '0;
            resp_err_q    <= 1'b0;
            resp_valid_q  <= 1'b0;
            req_ready_q   <= 1'b0;
            config_hsk_q  <= 1'b0;
            config_load_q <= 1'b0;
            config_addr_q <= '0;
            config_data_q <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            plain_q       <= plain_d;
            cnt_q         <= cnt_d;
            cache_vld_q   <= cache_vld_d;
            cache_key_q   <= cache_key_d;
            resp_cipher_q <= resp_cipher_d;
            resp_err_q    <= resp_err_d;
            resp_valid_q  <= resp_valid_d;
            req_ready_q   <= req_ready_d;
            config_hsk_q  <= config_hsk_d;
            config_load_q <= config_load_d;
            config_addr_q <= config_addr_d;
            config_data_q <= config_data_d;
        end
    end

    // Next state, request latching, key cache, wait counter and read capture.
    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        plain_d       = plain_q;
        cnt_d         = cnt_q;
        cache_vld_d   = cache_vld_q;
        cache_key_d   = cache_key_q;
        resp_cipher_d = resp_cipher_q;
        resp_err_d    = resp_err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    key_d   = req_key;
                    plain_d = req_plain;
                    if (KEY_CACHE && cache_vld_q && (req_key == cache_key_q))
                        state_d = WR_PH;
                    else
                        state_d = WR_KH;
                end
            end
            WR_KH: state_d = WR_KL;
            WR_KL: begin
                cache_key_d = key_q;
                cache_vld_d = 1'b1;
                state_d     = WR_PH;
            end
            WR_PH: state_d = WR_PL;
            WR_PL: begin
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 8'd0) state_d = RD_H;
                else               cnt_d   = cnt_q - 8'd1;
            end
            // Read data arrives in the same cycle as the load command; capture
            // regardless of aes_out_valid and flag the response instead.
            RD_H: begin
                resp_cipher_d[127:64] = aes_out_data;
                resp_err_d            = !aes_out_valid;
                state_d               = RD_L;
            end
            RD_L: begin
                resp_cipher_d[63:0] = aes_out_data;
                resp_err_d          = resp_err_q | !aes_out_valid;
                state_d             = RESP;
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_err_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are decoded from the upcoming state so commands appear
    // in the same cycle the FSM occupies the matching command state.
    always_comb begin
        config_hsk_d  = 1'b0;
        config_load_d = 1'b0;
        config_addr_d = '0;
        config_data_d = '0;
        req_ready_d   = (state_d == IDLE);
        resp_valid_d  = (state_d == RESP);
        unique case (state_d)
            WR_KH: begin config_hsk_d = 1'b1; config_addr_d = ADDR_KEY_HI; config_data_d = key_d[127:64];   end
            WR_KL: begin config_hsk_d = 1'b1; config_addr_d = ADDR_KEY_LO; config_data_d = key_d[63:0];     end
            WR_PH: begin config_hsk_d = 1'b1; config_addr_d = ADDR_PT_HI;  config_data_d = plain_d[127:64]; end
            WR_PL: begin config_hsk_d = 1'b1; config_addr_d = ADDR_PT_LO;  config_data_d = plain_d[63:0];   end
            RD_H:  begin config_hsk_d = 1'b1; config_load_d = 1'b1; config_addr_d = ADDR_CT_HI; end
            RD_L:  begin config_hsk_d = 1'b1; config_load_d = 1'b1; config_addr_d = ADDR_CT_LO; end
            default: ;
        endcase
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_cipher    = resp_cipher_q;
    assign resp_err       = resp_err_q;
    assign config_hsk     = config_hsk_q;
    assign config_load    = config_load_q;
    assign config_addr    = config_addr_q;
    assign config_data_hi = config_data_q[63:32];
    assign config_data_lo = config_data_q[31:0];

endmodule
